// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and move-legality helper for the pick-to-15 engine
package game_pkg;

  localparam int NUM_SQUARES = 9;

  typedef logic [3:0]             move_t;
  typedef logic [NUM_SQUARES-1:0] sq_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    OFFER,
    WAIT_RELEASE
  } entry_state_t;

  // Legal iff the value is 1..NUM_SQUARES and its square is still free.
  function automatic logic move_legal(input move_t m, input sq_mask_t t);
    logic [15:0] t_ext;
    move_t       idx;
    t_ext = {{(16-NUM_SQUARES){1'b0}}, t};
    idx   = m - 4'd1;
    return (m >= 4'd1) && (m <= 4'(NUM_SQUARES)) && !t_ext[idx];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer and counter debouncer for an active-low button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_L,
  input  logic raw_l_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample back at the accepted level restarts the run count.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = !sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_l_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/move_entry.sv
// rtl/move_entry.sv - human move entry: debounced buttons, legality check, valid/ready offer
module move_entry
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic [3:0] sw,
  input  logic       enter_L,
  input  logic       newGame_L,
  input  logic [8:0] taken,
  input  logic       humanTurn,
  input  logic       hMoveReady,
  output logic [3:0] hMove,
  output logic       hMoveValid,
  output logic       illegal,
  output logic       newGame
);

  logic ent_level, ent_press;
  logic ng_press, ng_level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clock   (clock),
    .reset_L (reset_L),
    .raw_l_i (enter_L),
    .level_o (ent_level),
    .press_o (ent_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_newgame_db (
    .clock   (clock),
    .reset_L (reset_L),
    .raw_l_i (newGame_L),
    .level_o (ng_level_unused),
    .press_o (ng_press)
  );

  entry_state_t state_q, state_d;
  move_t        sw_q, sw_d;
  move_t        hmove_q, hmove_d;
  logic         illegal_q, illegal_d;

  // New Game overrides every state; a held Enter cannot re-strobe, so IDLE waits for a fresh press.
  always_comb begin
    state_d   = state_q;
    sw_d      = sw_q;
    hmove_d   = hmove_q;
    illegal_d = illegal_q;
    if (ng_press) begin
      state_d   = IDLE;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ent_press) begin
            if (humanTurn) begin
              sw_d    = sw;
              state_d = CHECK;
            end else begin
              state_d = WAIT_RELEASE;
            end
          end
        end
        CHECK: begin
          if (move_legal(sw_q, sq_mask_t'(taken))) begin
            hmove_d   = sw_q;
            illegal_d = 1'b0;
            state_d   = OFFER;
          end else begin
            illegal_d = 1'b1;
            state_d   = WAIT_RELEASE;
          end
        end
        OFFER: begin
          if (hMoveReady) state_d = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (ent_level) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      sw_q      <= '0;
      hmove_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_q      <= sw_d;
      hmove_q   <= hmove_d;
      illegal_q <= illegal_d;
    end
  end

  assign hMove      = hmove_q;
  assign hMoveValid = (state_q == OFFER);
  assign illegal    = illegal_q;
  assign newGame    = ng_press;

endmodule

// File: tb/tb_move_entry.sv
// tb/tb_move_entry.sv - directed self-checking bench for move_entry
module tb_move_entry;

  logic       clock;
  logic       reset_L;
  logic [3:0] sw;
  logic       enter_L;
  logic       newGame_L;
  logic [8:0] taken;
  logic       humanTurn;
  logic       hMoveReady;
  logic [3:0] hMove;
  logic       hMoveValid;
  logic       illegal;
  logic       newGame;

  int nchecks = 0;
  int nerr    = 0;
  int vcnt;
  int ngcnt;

  move_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .sw         (sw),
    .enter_L    (enter_L),
    .newGame_L  (newGame_L),
    .taken      (taken),
    .humanTurn  (humanTurn),
    .hMoveReady (hMoveReady),
    .hMove      (hMove),
    .hMoveValid (hMoveValid),
    .illegal    (illegal),
    .newGame    (newGame)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Count cycles with hMoveValid high over n cycles.
  task automatic watch(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (hMoveValid) cnt++;
    end
  endtask

  // Hold Enter low for `hold` cycles, release, and let the FSM settle.
  task automatic press(input logic [3:0] s, input int hold, output int cnt);
    int c1, c2;
    sw      = s;
    enter_L = 1'b0;
    watch(hold, c1);
    enter_L = 1'b1;
    watch(10, c2);
    cnt = c1 + c2;
  endtask

  initial begin
    reset_L    = 1'b0;
    sw         = 4'd0;
    enter_L    = 1'b1;
    newGame_L  = 1'b1;
    taken      = 9'b0;
    humanTurn  = 1'b0;
    hMoveReady = 1'b0;
    step(2);
    chk("rst_hmove",   32'(hMove), 32'd0);
    chk("rst_valid",   32'(hMoveValid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_newgame", 32'(newGame), 32'd0);
    reset_L = 1'b1;
    step(2);

    // Legal move, latency and hold-off of a held Enter
    taken     = 9'b000010000;
    humanTurn = 1'b1;
    sw        = 4'd6;
    enter_L   = 1'b0;
    step(7);
    chk("lat_valid_early", 32'(hMoveValid), 32'd0);
    step(1);
    chk("lat_valid", 32'(hMoveValid), 32'd1);
    chk("lat_hmove", 32'(hMove), 32'd6);
    step(2);
    chk("hold_valid", 32'(hMoveValid), 32'd1);
    hMoveReady = 1'b1;
    step(1);
    hMoveReady = 1'b0;
    chk("accept_drop", 32'(hMoveValid), 32'd0);
    watch(20, vcnt);
    chk("held_no_second", 32'(vcnt), 32'd0);
    enter_L = 1'b1;
    step(10);

    // Illegal entries and recovery
    press(4'd5, 12, vcnt);
    chk("ill_taken_flag", 32'(illegal), 32'd1);
    chk("ill_taken_novalid", 32'(vcnt), 32'd0);
    press(4'd0, 12, vcnt);
    chk("ill_zero_flag", 32'(illegal), 32'd1);
    chk("ill_zero_novalid", 32'(vcnt), 32'd0);
    press(4'd10, 12, vcnt);
    chk("ill_ten_flag", 32'(illegal), 32'd1);
    chk("ill_ten_novalid", 32'(vcnt), 32'd0);
    hMoveReady = 1'b1;
    press(4'd9, 12, vcnt);
    hMoveReady = 1'b0;
    chk("legal9_flag", 32'(illegal), 32'd0);
    chk("legal9_hmove", 32'(hMove), 32'd9);
    chk("legal9_offers", 32'(vcnt), 32'd1);

    // Glitches and bounce are rejected; a clean 6-cycle press is not
    sw      = 4'd3;
    enter_L = 1'b0;
    step(3);
    enter_L = 1'b1;
    watch(12, vcnt);
    chk("glitch3_novalid", 32'(vcnt), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      enter_L = i[0];
      step(1);
      if (hMoveValid) vcnt++;
    end
    enter_L = 1'b1;
    step(10);
    chk("bounce_novalid", 32'(vcnt), 32'd0);
    hMoveReady = 1'b1;
    press(4'd3, 6, vcnt);
    hMoveReady = 1'b0;
    chk("clean6_offers", 32'(vcnt), 32'd1);
    chk("clean6_hmove", 32'(hMove), 32'd3);

    // New Game clears illegal when nothing is offered
    press(4'd5, 12, vcnt);
    chk("ng_pre_illegal", 32'(illegal), 32'd1);
    newGame_L = 1'b0;
    step(6);
    chk("ng_idle_pulse", 32'(newGame), 32'd1);
    step(1);
    chk("ng_idle_illegal", 32'(illegal), 32'd0);
    newGame_L = 1'b1;
    step(10);

    // New Game aborts an offer
    sw      = 4'd6;
    enter_L = 1'b0;
    step(8);
    chk("ng_offer_valid", 32'(hMoveValid), 32'd1);
    chk("ng_offer_hmove", 32'(hMove), 32'd6);
    newGame_L = 1'b0;
    step(5);
    chk("ng_pulse_early", 32'(newGame), 32'd0);
    chk("ng_still_valid", 32'(hMoveValid), 32'd1);
    ngcnt = 0;
    step(1);
    if (newGame) ngcnt++;
    chk("ng_pulse", 32'(newGame), 32'd1);
    step(1);
    if (newGame) ngcnt++;
    chk("ng_abort_valid", 32'(hMoveValid), 32'd0);
    chk("ng_abort_illegal", 32'(illegal), 32'd0);
    newGame_L = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (newGame) ngcnt++;
    end
    chk("ng_one_pulse", 32'(ngcnt), 32'd1);
    watch(10, vcnt);
    chk("ng_enter_ignored", 32'(vcnt), 32'd0);
    enter_L = 1'b1;
    step(10);

    // Press while not our turn, then turn arrives with Enter still held
    humanTurn = 1'b0;
    sw        = 4'd2;
    enter_L   = 1'b0;
    watch(10, vcnt);
    chk("noturn_novalid", 32'(vcnt), 32'd0);
    humanTurn = 1'b1;
    watch(10, vcnt);
    chk("turn_held_novalid", 32'(vcnt), 32'd0);
    enter_L = 1'b1;
    step(10);
    hMoveReady = 1'b1;
    press(4'd2, 12, vcnt);
    hMoveReady = 1'b0;
    chk("turn_repress_offers", 32'(vcnt), 32'd1);
    chk("turn_repress_hmove", 32'(hMove), 32'd2);

    // Asynchronous reset mid-offer
    sw      = 4'd6;
    enter_L = 1'b0;
    step(8);
    chk("arst_pre_valid", 32'(hMoveValid), 32'd1);
    #3;
    reset_L = 1'b0;
    enter_L = 1'b1;
    #1;
    chk("arst_valid",   32'(hMoveValid), 32'd0);
    chk("arst_illegal", 32'(illegal), 32'd0);
    chk("arst_newgame", 32'(newGame), 32'd0);
    chk("arst_hmove",   32'(hMove), 32'd0);
    step(1);
    reset_L = 1'b1;
    step(1);
    sw      = 4'd6;
    enter_L = 1'b0;
    step(7);
    chk("post_rst_early", 32'(hMoveValid), 32'd0);
    step(1);
    chk("post_rst_valid", 32'(hMoveValid), 32'd1);
    chk("post_rst_hmove", 32'(hMove), 32'd6);
    hMoveReady = 1'b1;
    step(1);
    hMoveReady = 1'b0;
    chk("post_rst_accept", 32'(hMoveValid), 32'd0);
    enter_L = 1'b1;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
